// File: rtl/flappy_pkg.sv
// flappy_pkg: shared types and constants for the Flappy frame scheduler.
package flappy_pkg;

    localparam int NUM_PIPES_DEF = 4;
    localparam int PIPE_IDX_W    = 2;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_W       = 2 * BCD_DIGIT_W;
    localparam logic [BCD_W-1:0] BCD_SAT = 8'h99;

    typedef enum logic [1:0] {
        G_INIT = 2'd0,
        G_PLAY = 2'd1,
        G_LOSE = 2'd2
    } game_e;

    typedef enum logic [1:0] {
        F_WAIT   = 2'd0,
        F_PHYS   = 2'd1,
        F_SCROLL = 2'd2,
        F_CHECK  = 2'd3
    } frame_e;

    // Well-formed BCD values order the same way as plain binary.
    function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/flappy_bcd_counter.sv
// flappy_bcd_counter: two-digit BCD incrementer with synchronous clear,
// saturating at 99.
module flappy_bcd_counter
    import flappy_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [BCD_W-1:0] count_o
);

    logic [BCD_DIGIT_W-1:0] units_q, units_d;
    logic [BCD_DIGIT_W-1:0] tens_q,  tens_d;

    // Next count: clear wins, otherwise increment with units->tens carry unless saturated.
    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (clr_i) begin
            units_d = '0;
            tens_d  = '0;
        end else if (inc_i && ({tens_q, units_q} != BCD_SAT)) begin
            if (units_q == BCD_DIGIT_W'(9)) begin
                units_d = '0;
                tens_d  = tens_q + 1'b1;
            end else begin
                units_d = units_q + 1'b1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign count_o = {tens_q, units_q};

endmodule

// File: rtl/flappy_frame_scheduler.sv
// flappy_frame_scheduler: single-clock game sequencer. Each frame tick in PLAY
// issues a physics step, a pipe scroll and a per-pipe collision/score scan.
// Optional feature macro: FLAPPY_HISCORE_EN (best-score register).
module flappy_frame_scheduler
    import flappy_pkg::*;
#(
    parameter int TICK_DIV  = 1666667,
    parameter int NUM_PIPES = NUM_PIPES_DEF
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  start_pulse,
    input  logic                  ack_pulse,
    input  logic                  jump_pulse,
    input  logic                  hit,
    input  logic                  passed,
    output logic                  physics_en,
    output logic                  jump_out,
    output logic                  scroll_en,
    output logic [PIPE_IDX_W-1:0] pipe_index,
    output logic                  q_Initial,
    output logic                  q_Play,
    output logic                  q_Lose,
    output logic [BCD_W-1:0]      score_bcd,
    output logic [BCD_W-1:0]      hiscore_bcd
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    game_e                 game_q, game_d;
    frame_e                frame_q, frame_d;
    logic [PIPE_IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  jump_req_q, jump_req_d;
    logic                  tick;
    logic                  score_clr, score_inc;

    logic                  phys_q, scroll_q;
    logic [PIPE_IDX_W-1:0] pidx_q;
    logic                  init_q, play_q, lose_q;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next-state logic for game state, frame sub-state, tick divider and jump latch.
    always_comb begin
        game_d     = game_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        jump_req_d = jump_req_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        unique case (game_q)
            G_INIT: begin
                jump_req_d = 1'b0;
                if (start_pulse) begin
                    game_d    = G_PLAY;
                    frame_d   = F_WAIT;
                    idx_d     = '0;
                    cnt_d     = '0;
                    score_clr = 1'b1;
                end
            end
            G_PLAY: begin
                if (jump_pulse) jump_req_d = 1'b1;
                unique case (frame_q)
                    F_WAIT: begin
                        if (tick) frame_d = F_PHYS;
                    end
                    F_PHYS: begin
                        // Request (or same-cycle press) is consumed by this step.
                        jump_req_d = 1'b0;
                        frame_d    = F_SCROLL;
                    end
                    F_SCROLL: begin
                        frame_d = F_CHECK;
                        idx_d   = '0;
                    end
                    F_CHECK: begin
                        if (hit) begin
                            // Collision ends the scan; hit beats passed.
                            game_d  = G_LOSE;
                            frame_d = F_WAIT;
                            idx_d   = '0;
                        end else begin
                            score_inc = passed;
                            if (idx_q == PIPE_IDX_W'(NUM_PIPES - 1)) begin
                                frame_d = F_WAIT;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    end
                    default: frame_d = F_WAIT;
                endcase
            end
            G_LOSE: begin
                jump_req_d = 1'b0;
                if (ack_pulse) game_d = G_INIT;
            end
            default: begin
                game_d  = G_INIT;
                frame_d = F_WAIT;
                idx_d   = '0;
            end
        endcase
    end

    // State, divider and jump-latch registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            game_q     <= G_INIT;
            frame_q    <= F_WAIT;
            idx_q      <= '0;
            cnt_q      <= '0;
            jump_req_q <= 1'b0;
        end else begin
            game_q     <= game_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            jump_req_q <= jump_req_d;
        end
    end

    // Output registers, decoded from next state so they line up with the state they describe.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            phys_q   <= 1'b0;
            scroll_q <= 1'b0;
            pidx_q   <= '0;
            init_q   <= 1'b1;
            play_q   <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            phys_q   <= (game_d == G_PLAY) && (frame_d == F_PHYS);
            scroll_q <= (game_d == G_PLAY) && (frame_d == F_SCROLL);
            pidx_q   <= ((game_d == G_PLAY) && (frame_d == F_CHECK)) ? idx_d : '0;
            init_q   <= (game_d == G_INIT);
            play_q   <= (game_d == G_PLAY);
            lose_q   <= (game_d == G_LOSE);
        end
    end

    assign physics_en = phys_q;
    assign scroll_en  = scroll_q;
    assign pipe_index = pidx_q;
    assign q_Initial  = init_q;
    assign q_Play     = play_q;
    assign q_Lose     = lose_q;

    // jump_out is gated by the registered step enable but also ORs in a press
    // arriving in the step cycle itself, so that press lands in this frame.
    assign jump_out = phys_q & (jump_req_q | jump_pulse);

    flappy_bcd_counter u_score (
        .clk_i  (Clk),
        .rst_ni (reset),
        .clr_i  (score_clr),
        .inc_i  (score_inc),
        .count_o(score_bcd)
    );

`ifdef FLAPPY_HISCORE_EN
    logic             lose_evt;
    logic [BCD_W-1:0] hiscore_q;

    // Score cannot change on the losing edge (hit beats passed), so score_bcd is final here.
    assign lose_evt = (game_q == G_PLAY) && (frame_q == F_CHECK) && hit;

    // Best-score capture on PLAY->LOSE; only reset clears it.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            hiscore_q <= '0;
        end else if (lose_evt && bcd_gt(score_bcd, hiscore_q)) begin
            hiscore_q <= score_bcd;
        end
    end

    assign hiscore_bcd = hiscore_q;
`else
    assign hiscore_bcd = '0;
`endif

endmodule
